// File: rtl/jogo_pkg.sv
// jogo_pkg: shared game encodings and screen constants
package jogo_pkg;
    typedef enum logic [1:0] {IDLE, VOO, RECARGA} estado_t;
    localparam logic [9:0] PARK = 10'h3FF;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
endpackage

// File: rtl/detector_borda.sv
// detector_borda: registered falling-edge detector, history resets high
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal_n,
    output logic borda
);
    logic prev_q, prev_d, borda_q, borda_d;
    always_comb begin
        prev_d  = sinal_n;
        borda_d = prev_q & ~sinal_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b1;
            borda_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            borda_q <= borda_d;
        end
    end
    assign borda = borda_q;
endmodule

// File: rtl/municao_jogador.sv
// municao_jogador: player bullet FSM, motion, reload cooldown, shot counter and pixel painter
module municao_jogador
    import jogo_pkg::*;
#(
    parameter int unsigned SPEED    = 4,
    parameter int unsigned BULLET_W = 2,
    parameter int unsigned BULLET_H = 6,
    parameter int unsigned PLAYER_W = 24,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fire_n,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       colisao,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [9:0] posX_municao_player,
    output logic [9:0] posY_municao_player,
    output logic       ativa,
    output logic [7:0] disparos,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);
    localparam logic [9:0] SPD  = 10'(SPEED);
    localparam logic [9:0] BH   = 10'(BULLET_H);
    localparam logic [9:0] OFSX = 10'(PLAYER_W / 2) - 10'(BULLET_W / 2);
    localparam logic [7:0] CD   = 8'(COOLDOWN);

    estado_t    estado_q, estado_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [7:0] cnt_q, cnt_d, disp_q, disp_d;
    logic       fire, pix;

    detector_borda u_borda (
        .clk     (clk),
        .reset   (reset),
        .sinal_n (fire_n),
        .borda   (fire)
    );

    always_comb begin
        estado_d = estado_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        disp_d   = disp_q;
        case (estado_q)
            IDLE: if (fire && player_y >= BH) begin
                estado_d = VOO;
                x_d      = player_x + OFSX;
                y_d      = player_y - BH;
                disp_d   = disp_q + 8'd1;
            end
            // colisao outranks a same-cycle tick; the Y < SPEED test avoids wrapping past the top
            VOO: if (colisao || (tick && y_q < SPD)) begin
                estado_d = RECARGA;
                x_d      = PARK;
                y_d      = PARK;
                cnt_d    = CD;
            end else if (tick) begin
                y_d = y_q - SPD;
            end
            RECARGA: if (cnt_q == 8'd0) estado_d = IDLE;
                     else if (tick) cnt_d = cnt_q - 8'd1;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
            x_q      <= PARK;
            y_q      <= PARK;
            cnt_q    <= 8'd0;
            disp_q   <= 8'd0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
        end
    end

    assign ativa               = (estado_q == VOO);
    assign posX_municao_player = x_q;
    assign posY_municao_player = y_q;
    assign disparos            = disp_q;

    // 11-bit bounds so a bullet near the right/bottom edge does not wrap
    assign pix = !reset && ativa
              && h_counter >= x_q && {1'b0, h_counter} < {1'b0, x_q} + 11'(BULLET_W)
              && v_counter >= y_q && {1'b0, v_counter} < {1'b0, y_q} + 11'(BULLET_H);
    assign R = {8{pix}};
    assign G = {8{pix}};
    assign B = {8{pix}};
endmodule

// File: tb/tb_municao_jogador.sv
// tb_municao_jogador: directed vector and sequence checks for the player bullet
module tb_municao_jogador;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, fire_n = 1'b1, colisao = 1'b0;
    logic [9:0] player_x = 10'd0, player_y = 10'd0, h_counter = 10'd0, v_counter = 10'd0;
    logic [9:0] px, py;
    logic       ativa;
    logic [7:0] disparos, R, G, B;
    int         pass_cnt = 0, total = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [7:0] rgb;
    } vec_t;
    vec_t vt[10];

    municao_jogador dut (
        .clk                 (clk),
        .reset               (reset),
        .tick                (tick),
        .fire_n              (fire_n),
        .player_x            (player_x),
        .player_y            (player_y),
        .colisao             (colisao),
        .h_counter           (h_counter),
        .v_counter           (v_counter),
        .posX_municao_player (px),
        .posY_municao_player (py),
        .ativa               (ativa),
        .disparos            (disparos),
        .R                   (R),
        .G                   (G),
        .B                   (B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
        end
    endtask

    task automatic shoot();
        fire_n = 1'b0;
        step(2);
        fire_n = 1'b1;
    endtask

    task automatic retire();
        colisao = 1'b1;
        step(1);
        colisao = 1'b0;
        do_tick(8);
        step(1);
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, output int c);
        h_counter = h;
        v_counter = v;
        #1;
        c = (R == G && G == B) ? int'(R) : -1;
    endtask

    initial begin
        int c, e;
        vt[0] = '{10'd320, 10'd240, 8'hFF};
        vt[1] = '{10'd321, 10'd245, 8'hFF};
        vt[2] = '{10'd321, 10'd240, 8'hFF};
        vt[3] = '{10'd320, 10'd245, 8'hFF};
        vt[4] = '{10'd319, 10'd240, 8'h00};
        vt[5] = '{10'd322, 10'd240, 8'h00};
        vt[6] = '{10'd320, 10'd239, 8'h00};
        vt[7] = '{10'd320, 10'd246, 8'h00};
        vt[8] = '{10'd322, 10'd246, 8'h00};
        vt[9] = '{10'd0,   10'd0,   8'h00};

        step(2);
        pix(10'd1023, 10'd1023, c);
        chk("rgb_in_reset", c, 0);
        reset = 1'b0;
        step(1);
        chk("rst_x", int'(px), 1023);
        chk("rst_y", int'(py), 1023);
        chk("rst_ativa", int'(ativa), 0);
        chk("rst_disparos", int'(disparos), 0);

        player_x = 10'd100;
        player_y = 10'd400;
        fire_n = 1'b0;
        step(1);
        chk("latency_1clk_ativa", int'(ativa), 0);
        step(1);
        chk("spawn_ativa", int'(ativa), 1);
        chk("spawn_x", int'(px), 111);
        chk("spawn_y", int'(py), 394);
        chk("spawn_disparos", int'(disparos), 1);
        do_tick(10);
        chk("ticks10_y", int'(py), 354);
        chk("ticks10_x", int'(px), 111);
        step(1000);
        chk("hold_one_shot", int'(disparos), 1);
        fire_n = 1'b1;
        step(2);
        shoot();
        step(2);
        chk("fire_in_voo", int'(disparos), 1);
        chk("fire_in_voo_y", int'(py), 354);

        do_tick(88);
        chk("y_at_2", int'(py), 2);
        do_tick(1);
        chk("top_exit_x", int'(px), 1023);
        chk("top_exit_y", int'(py), 1023);
        chk("top_exit_ativa", int'(ativa), 0);
        do_tick(7);
        fire_n = 1'b0;
        step(4);
        chk("fire_in_recarga", int'(disparos), 1);
        chk("fire_in_recarga_ativa", int'(ativa), 0);
        fire_n = 1'b1;
        do_tick(1);
        step(1);
        player_y = 10'd206;
        shoot();
        chk("refire_after_cd", int'(disparos), 2);
        chk("refire_y", int'(py), 200);

        colisao = 1'b1;
        tick = 1'b1;
        step(1);
        colisao = 1'b0;
        tick = 1'b0;
        chk("col_tick_y", int'(py), 1023);
        chk("col_tick_ativa", int'(ativa), 0);
        do_tick(8);
        step(1);

        player_y = 10'd3;
        shoot();
        step(2);
        chk("low_player_ativa", int'(ativa), 0);
        chk("low_player_disparos", int'(disparos), 2);
        player_y = 10'd6;
        shoot();
        chk("edge_player_y", int'(py), 0);
        do_tick(1);
        chk("y0_tick_park", int'(py), 1023);
        do_tick(8);
        step(1);

        player_x = 10'd309;
        player_y = 10'd246;
        shoot();
        chk("paint_pos_x", int'(px), 320);
        chk("paint_pos_y", int'(py), 240);
        for (int i = 0; i < 10; i++) begin
            pix(vt[i].h, vt[i].v, c);
            chk($sformatf("rgb_vec%0d", i), c, int'(vt[i].rgb));
        end
        for (int h = 316; h < 326; h++)
            for (int v = 236; v < 250; v++) begin
                e = (h >= 320 && h <= 321 && v >= 240 && v <= 245) ? 255 : 0;
                pix(10'(h), 10'(v), c);
                chk($sformatf("sweep_%0d_%0d", h, v), c, e);
            end
        retire();
        pix(10'd320, 10'd240, c);
        chk("rgb_inactive", c, 0);

        player_y = 10'd256;
        shoot();
        chk("pre_reset_y", int'(py), 250);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset_ativa", int'(ativa), 0);
        chk("mid_reset_y", int'(py), 1023);
        chk("mid_reset_disparos", int'(disparos), 0);
        step(1);

        player_y = 10'd400;
        for (int i = 0; i < 255; i++) begin
            shoot();
            retire();
        end
        chk("disparos_255", int'(disparos), 255);
        shoot();
        chk("disparos_wrap", int'(disparos), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
